// File: rtl/brp_resolve.sv
// brp_resolve: resolves queued branch predictions oldest-first and feeds back update/flush/statistics.
// Latency: upd_valid/upd_correct/flush/redirect_pc/counters are registered, 1 cycle after the accepted resolve.
// Backpressure: pred_ready low when the queue is full or during flush; resolves are never stalled.
// Ports: pred_* = fetch push side (valid/ready); res_* = execute resolve side (oldest entry);
//        upd_* = predictor update strobe; flush/redirect_pc = mispredict recovery;
//        empty, err_underflow, num_branches, num_mispredicts = status and statistics.
module brp_resolve #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic [XLEN-1:0]  pred_target,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             upd_valid,
  output logic             upd_correct,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             empty,
  output logic             err_underflow,
  output logic [CNT_W-1:0] num_branches,
  output logic [CNT_W-1:0] num_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      OCC_FULL = DEPTH[PW:0];
  localparam logic [PW:0]      OCC_ONE  = 1;
  localparam logic [PW-1:0]    PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [XLEN-1:0]  INSN_SZ  = 4;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_wr_d;
  logic             ent_we_d;
  ent_t             head;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic             upd_valid_q, upd_valid_d;
  logic             upd_correct_q, upd_correct_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] nb_q, nb_d, nm_q, nm_d;
  logic             push, pop, mispredict;

  // Ready depends on registered state only, never on res_valid.
  assign empty           = (occ_q == '0);
  assign pred_ready      = (occ_q != OCC_FULL) && !flush_q;
  assign upd_valid       = upd_valid_q;
  assign upd_correct     = upd_correct_q;
  assign flush           = flush_q;
  assign redirect_pc     = redirect_pc_q;
  assign err_underflow   = err_q;
  assign num_branches    = nb_q;
  assign num_mispredicts = nm_q;

  always_comb begin
    head          = ent_q[rd_ptr_q];
    push          = pred_valid && pred_ready;
    pop           = res_valid && !empty;
    // Target only matters when both sides agree the branch was taken.
    mispredict    = pop && ((res_taken != head.taken) ||
                            (res_taken && head.taken && (res_target != head.target)));

    upd_valid_d   = pop;
    upd_correct_d = pop && !mispredict;
    flush_d       = mispredict;
    redirect_pc_d = redirect_pc_q;
    err_d         = err_q || (res_valid && empty);
    nb_d          = nb_q;
    nm_d          = nm_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    ent_we_d      = push && !mispredict;
    ent_wr_d      = '{taken: pred_taken, pc: pred_pc, target: pred_target};

    if (pop && (nb_q != '1)) nb_d = nb_q + CNT_ONE;

    if (mispredict) begin
      // Everything younger than the mispredicted branch is wrong-path: drop it all.
      redirect_pc_d = res_taken ? res_target : (head.pc + INSN_SZ);
      if (nm_q != '1) nm_d = nm_q + CNT_ONE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_correct_q <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
      nb_q          <= '0;
      nm_q          <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      upd_valid_q   <= upd_valid_d;
      upd_correct_q <= upd_correct_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
      nb_q          <= nb_d;
      nm_q          <= nm_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (ent_we_d) ent_q[wr_ptr_q] <= ent_wr_d;
  end

endmodule
